// File: rtl/aes128_encrypt_core.sv
// ============================================================================
// Module : aes128_encrypt_core
// Brief  : Iterative AES-128 encryptor, one round per clock, on-the-fly keys.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes128_encrypt_core #(
    parameter int DONE_HOLD = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plain_text_in,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] cipher_out
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_round = 1'b1;

    logic [0:0]   r_fsm;
    logic [0:0]   w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [127:0] r_cipher;
    logic         r_done;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_next_key;
    logic [31:0]  w_key_sub;
    logic [31:0]  w_key_temp;
    logic [7:0]   w_rcon;
    logic         w_round_valid;
    logic         w_accept;
    logic         w_complete;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box built as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte i lives at [127-8i -: 8]; column-major, index = row + 4*col.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign w_sub[127-8*i -: 8] = sbox(r_state[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shift[127-8*(r+4*c) -: 8] = w_sub[127-8*(r+4*((c+r)%4)) -: 8];
        end
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_shift[127-8*(4*c)   -: 8];
        assign w_a1 = w_shift[127-8*(4*c+1) -: 8];
        assign w_a2 = w_shift[127-8*(4*c+2) -: 8];
        assign w_a3 = w_shift[127-8*(4*c+3) -: 8];
        assign w_mix[127-8*(4*c)   -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mix[127-8*(4*c+1) -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mix[127-8*(4*c+2) -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mix[127-8*(4*c+3) -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    always_comb begin
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // SubWord(RotWord(w3)): rotated byte k comes from w3 byte (k+1)%4.
    for (genvar k = 0; k < 4; k++) begin : g_key_sbox
        assign w_key_sub[31-8*k -: 8] = sbox(r_key[31-8*((k+1)%4) -: 8]);
    end

    assign w_key_temp            = w_key_sub ^ {w_rcon, 24'h000000};
    assign w_next_key[127:96]    = r_key[127:96] ^ w_key_temp;
    assign w_next_key[95:64]     = r_key[95:64]  ^ w_next_key[127:96];
    assign w_next_key[63:32]     = r_key[63:32]  ^ w_next_key[95:64];
    assign w_next_key[31:0]      = r_key[31:0]   ^ w_next_key[63:32];

    assign w_round_valid = (r_round >= 4'd1) && (r_round <= 4'd10);
    assign w_accept      = (r_fsm == c_st_idle) && start;
    assign w_complete    = (r_fsm == c_st_round) && (r_round == 4'd10);

    always_ff @(posedge clock) begin
        if (!reset) r_fsm <= c_st_idle;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_st_idle:  if (start) w_fsm_next = c_st_round;
            c_st_round: if (!w_round_valid || r_round == 4'd10) w_fsm_next = c_st_idle;
            default:    w_fsm_next = c_st_idle;
        endcase
    end

    always_comb begin
        ready = (r_fsm == c_st_idle);
        busy  = (r_fsm == c_st_round);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= '0;
            r_key    <= '0;
            r_round  <= '0;
            r_cipher <= '0;
        end else if (w_accept) begin
            r_state <= plain_text_in ^ key_in;
            r_key   <= key_in;
            r_round <= 4'd1;
        end else if (r_fsm == c_st_round) begin
            if (w_round_valid) begin
                r_key   <= w_next_key;
                r_round <= r_round + 4'd1;
                if (r_round == 4'd10) r_cipher <= w_shift ^ w_next_key;
                else                  r_state  <= w_mix ^ w_next_key;
            end else begin
                r_round <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)                          r_done <= 1'b0;
        else if (w_complete)                 r_done <= 1'b1;
        else if (DONE_HOLD == 0 || w_accept) r_done <= 1'b0;
    end

    assign done       = r_done;
    assign cipher_out = r_cipher;

endmodule

`default_nettype wire

// File: doc/aes128_encrypt_core.md
Name: aes128_encrypt_core

Overview:
Iterative AES-128 encryption engine, one round per clock. It is the forward-direction counterpart of the team's iterative decryption datapath. It accepts a plaintext/key pair through a start/ready handshake and computes round keys on the fly, so no key pre-expansion phase and no key bank are needed. It returns the ciphertext in a held output register with a done indication, and will feed the SD-card write path.

Parameters:
DONE_HOLD, 0, 0 = done is a one-cycle pulse; 1 = done stays high until the next accepted start or reset.

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising clock edge)
start  input  1  request to encrypt; sampled only while ready=1
plain_text_in  input  128  plaintext; bits [127:120] = byte 0 (FIPS-197 order)
key_in  input  128  cipher key, same byte order
ready  output  1  high in IDLE; a start is accepted on an edge where start=1 and ready=1
busy  output  1  high from the accept edge until the completing edge
done  output  1  completion indication (see DONE_HOLD)
cipher_out  output  128  ciphertext; valid while done=1 and held until the next completion

Behaviour:
- Reset (reset=0 at an edge), including mid-operation:
  - FSM goes to IDLE.
  - state, round key, round counter and cipher_out are all cleared to 0.
  - ready=1, busy=0, done=0.
  - Any encryption in progress is abandoned with no done.
- FSM states: IDLE and ROUND.
  - IDLE: ready=1, busy=0.
  - ROUND: ready=0, busy=1.
- Accept edge E0 (IDLE, start=1):
  - state_reg <= plain_text_in ^ key_in.
  - key_reg <= key_in.
  - round <= 1; go to ROUND.
  - Inputs are not sampled again after E0 and may change freely.
- Round edges E1..E10 (ROUND, round = r):
  - next_key = key schedule step of key_reg using Rcon[r]; Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - r = 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_key.
  - r = 10: no MixColumns; cipher_out <= ShiftRows(SubBytes(state_reg)) ^ next_key; go to IDLE.
  - Every round edge: key_reg <= next_key; round <= r+1.
- Only one S-box bank (16 S-boxes) is used for state plus 4 for the key schedule; all combinational between registers.
- Latency: 11 rising edges from the accept edge to cipher_out update.
  - done and cipher_out become visible in the cycle after E10.
  - Throughput: one block per 11 cycles (back-to-back start allowed, see below).
- done:
  - DONE_HOLD=0: done=1 for exactly the one cycle after E10.
  - DONE_HOLD=1: done=1 from after E10 until the edge that accepts the next start (cleared at that edge) or reset.
- start while busy=1: ignored, with no queuing and no effect on the running operation.
- start=1 in the cycle done=1: FSM is already in IDLE, so the start is accepted. With DONE_HOLD=0, done falls at that edge as usual. cipher_out keeps the old result until the new E10.
- The round counter is 4 bits. Values 0 and 11..15 are unreachable; if one is ever reached, the FSM returns to IDLE with no done.
- cipher_out changes only at E10 or reset.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, start pulse -> done exactly 11 edges after accept; cipher_out = 69c4e0d86a7b0430d8cdb78070b4c55a; ready low for cycles 1..10.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> cipher_out = 3925841d02dc09fbdc118597196a0b32. Change inputs to random values after the accept edge -> result unchanged.
- Back-to-back: hold start=1 continuously with C.1 then B vectors.
  - Second accept occurs in the done cycle of the first.
  - Outputs are 69c4e0d8... then 3925841d..., 11 cycles apart.
  - With DONE_HOLD=0, done is low between them.
- start pulses at cycles 3 and 7 of an encryption -> ignored; single done; correct ciphertext.
- Drive reset=0 for one edge at round 5 -> ready=1, busy=0, done=0 and cipher_out=0 on the next cycle, with no later done. A fresh C.1 run afterwards gives 69c4e0d86a7b0430d8cdb78070b4c55a.
- DONE_HOLD=1: done stays high for 20 idle cycles after completion and clears at the next accept edge. Round-trip: the output fed to the team decryption datapath returns 00112233445566778899aabbccddeeff.
